job_status_writer: RTL and testbench

JOB_STATUS_WRITER -- requirements
Module: job_status_writer

---
 rtl/job_status_writer.sv | 159 +++++++++++++++
 tb/tb_job_status_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_status_writer.sv
// Job status writer: round-robin arbitration of per-queue status entries into
// per-queue ring buffers over a credit-limited memory write port.
module job_status_writer #(
  parameter int NUM_JOB_TYPES   = 4,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            writer_enable,
  input  logic [NUM_JOB_TYPES-1:0][31:0]  status_queue_base_addr,
  input  logic [31:0]                     status_queue_size,
  input  logic [NUM_JOB_TYPES-1:0][511:0] job_status_in,
  input  logic [NUM_JOB_TYPES-1:0]        job_status_valid,
  output logic [NUM_JOB_TYPES-1:0]        job_status_ready,
  output logic [31:0]                     jsw_tx_wr_addr,
  output logic [TAG_W-1:0]                jsw_tx_wr_tag,
  output logic [511:0]                    jsw_tx_wr_data,
  output logic                            jsw_tx_wr_valid,
  input  logic                            jsw_tx_wr_ready,
  input  logic                            jsw_rx_wr_valid,
  input  logic [TAG_W-1:0]                jsw_rx_wr_tag,
  output logic [NUM_JOB_TYPES-1:0][31:0]  done_count,
  output logic                            writer_idle
);

  localparam int QW = $clog2(NUM_JOB_TYPES);
  localparam int SW = TAG_W - QW;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic                             r_tx_valid;
  logic [31:0]                      r_tx_addr;
  logic [TAG_W-1:0]                 r_tx_tag;
  logic [511:0]                     r_tx_data;
  logic [QW-1:0]                    r_rr_ptr;
  logic [NUM_JOB_TYPES-1:0][31:0]   r_wr_ptr;
  logic [NUM_JOB_TYPES-1:0][SW-1:0] r_seq;
  logic [NUM_JOB_TYPES-1:0][31:0]   r_done;
  logic [OW-1:0]                    r_outstanding;

  logic          w_any;
  logic [QW-1:0] w_grant;
  logic          w_credit;
  logic          w_can_accept;
  logic          w_accept;
  logic          w_tx_hs;
  logic          w_rx_ok;
  logic [QW-1:0] w_rx_q;
  logic          w_unused_tag;

  assign jsw_tx_wr_addr  = r_tx_addr;
  assign jsw_tx_wr_tag   = r_tx_tag;
  assign jsw_tx_wr_data  = r_tx_data;
  assign jsw_tx_wr_valid = r_tx_valid;
  assign done_count      = r_done;

  assign w_tx_hs      = r_tx_valid & jsw_tx_wr_ready;
  assign w_rx_ok      = jsw_rx_wr_valid & (r_outstanding != '0);
  assign w_rx_q       = jsw_rx_wr_tag[TAG_W-1 -: QW];
  assign w_unused_tag = ^jsw_rx_wr_tag[SW-1:0];

  // The registered TX entry still holds a credit until it handshakes.
  assign w_credit = (32'(r_outstanding) + 32'(r_tx_valid)) < 32'(MAX_OUTSTANDING);
  assign w_can_accept = rst_n & writer_enable & (r_state == S_RUN) &
                        (~r_tx_valid | jsw_tx_wr_ready) & w_credit;
  assign w_accept = w_can_accept & w_any;

  // Downward scan so the last hit is the nearest valid queue at or after rr_ptr.
  always_comb begin
    int idx;
    w_any   = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = NUM_JOB_TYPES - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_JOB_TYPES) idx = idx - NUM_JOB_TYPES;
      if (job_status_valid[idx]) begin
        w_any   = 1'b1;
        w_grant = QW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    writer_idle      = (r_state == S_IDLE);
    job_status_ready = '0;
    if (w_accept) job_status_ready[w_grant] = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (writer_enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!writer_enable) begin
          if ((r_outstanding != '0) || r_tx_valid) w_state_nxt = S_DRAIN;
          else                                     w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (writer_enable)                                w_state_nxt = S_RUN;
        else if ((r_outstanding == '0) && !r_tx_valid)    w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_addr  <= '0;
      r_tx_tag   <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_seq      <= '0;
    end else begin
      if (w_accept) begin
        r_tx_valid <= 1'b1;
        r_tx_addr  <= status_queue_base_addr[w_grant] + r_wr_ptr[w_grant];
        r_tx_tag   <= {w_grant, r_seq[w_grant]};
        r_rr_ptr   <= (w_grant == QW'(NUM_JOB_TYPES - 1)) ? '0 : w_grant + QW'(1);
        r_seq[w_grant] <= r_seq[w_grant] + SW'(1);
        if (r_wr_ptr[w_grant] >= status_queue_size - 32'd1) r_wr_ptr[w_grant] <= '0;
        else                                               r_wr_ptr[w_grant] <= r_wr_ptr[w_grant] + 32'd1;
      end else if (w_tx_hs) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tx_data <= job_status_in[w_grant];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_done        <= '0;
    end else begin
      case ({w_tx_hs, w_rx_ok})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      // Completions for an out-of-range queue index still return their credit.
      if (w_rx_ok && (32'(w_rx_q) < 32'(NUM_JOB_TYPES)))
        r_done[w_rx_q] <= r_done[w_rx_q] + 32'd1;
    end
  end

endmodule

// File: tb/tb_job_status_writer.sv
// Directed bench for job_status_writer: single write, ring wrap, arbitration,
// backpressure, credit limit, drain and mid-operation reset.
module tb_job_status_writer;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [3:0][31:0]  base;
  logic [31:0]       qsize;
  logic [3:0][511:0] jdata;
  logic [3:0]        jvalid;
  logic [3:0]        jready;
  logic [31:0]       tx_addr;
  logic [7:0]        tx_tag;
  logic [511:0]      tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              rx_valid;
  logic [7:0]        rx_tag;
  logic [3:0][31:0]  done;
  logic              idle;

  int errors = 0;
  int checks = 0;
  int acc;

  job_status_writer dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .writer_enable          (en),
    .status_queue_base_addr (base),
    .status_queue_size      (qsize),
    .job_status_in          (jdata),
    .job_status_valid       (jvalid),
    .job_status_ready       (jready),
    .jsw_tx_wr_addr         (tx_addr),
    .jsw_tx_wr_tag          (tx_tag),
    .jsw_tx_wr_data         (tx_data),
    .jsw_tx_wr_valid        (tx_valid),
    .jsw_tx_wr_ready        (tx_ready),
    .jsw_rx_wr_valid        (rx_valid),
    .jsw_rx_wr_tag          (rx_tag),
    .done_count             (done),
    .writer_idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic respond(input logic [7:0] tag);
    rx_valid = 1'b1;
    rx_tag   = tag;
    tick();
    rx_valid = 1'b0;
  endtask

  int          arb_g [5] = '{0, 1, 2, 3, 0};
  logic [31:0] arb_a [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h1001};
  logic [7:0]  arb_t [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01};
  logic [7:0]  arb_r [8] = '{8'h00, 8'h01, 8'h40, 8'h80, 8'h81, 8'h82, 8'h83, 8'hC0};

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    base[0]  = 32'h1000;
    base[1]  = 32'h2000;
    base[2]  = 32'h3000;
    base[3]  = 32'h4000;
    qsize    = 32'd4;
    jdata    = '0;
    jvalid   = 4'b0000;
    tx_ready = 1'b1;
    rx_valid = 1'b0;
    rx_tag   = 8'h00;
    tick();
    tick();

    // reset state
    chk("rst_ready", 32'(jready), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_txvalid", 32'(tx_valid), 32'h0);
    chk("rst_addr", tx_addr, 32'h0);
    chk("rst_tag", 32'(tx_tag), 32'h0);
    chkw("rst_done", 512'(done), 512'h0);

    // single entry on queue 0
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("run_idle", 32'(idle), 32'h0);
    jvalid   = 4'b0001;
    jdata[0] = {16{32'hD0D0_0000}};
    #1;
    chk("single_ready", 32'(jready), 32'h1);
    tick();
    jvalid = 4'b0000;
    chk("single_valid", 32'(tx_valid), 32'h1);
    chk("single_addr", tx_addr, 32'h1000);
    chk("single_tag", 32'(tx_tag), 32'h00);
    chkw("single_data", tx_data, {16{32'hD0D0_0000}});
    tick();
    chk("single_hs", 32'(tx_valid), 32'h0);
    respond(8'h00);
    chk("single_done", done[0], 32'd1);

    // ring wrap on queue 1 with size 3
    qsize = 32'd3;
    for (int k = 0; k < 5; k++) begin
      jvalid   = 4'b0010;
      jdata[1] = {16{32'(32'h1100_0000 + k)}};
      #1;
      chk("wrap_ready", 32'(jready), 32'h2);
      tick();
      chk("wrap_addr", tx_addr, 32'(32'h2000 + (k % 3)));
      chk("wrap_tag", 32'(tx_tag), 32'(8'h40 + k));
      chkw("wrap_data", tx_data, {16{32'(32'h1100_0000 + k)}});
    end
    jvalid = 4'b0000;
    tick();
    chk("wrap_hs", 32'(tx_valid), 32'h0);
    for (int k = 0; k < 5; k++) respond(8'(8'h40 + k));
    chk("wrap_done1", done[1], 32'd5);
    chk("wrap_done0", done[0], 32'd1);

    // reset with a write held pending
    jvalid   = 4'b0010;
    jdata[1] = {16{32'h5555_5555}};
    #1;
    tick();
    jvalid   = 4'b0000;
    tx_ready = 1'b0;
    chk("pre_rst_addr", tx_addr, 32'h2002);
    chk("pre_rst_tag", 32'(tx_tag), 32'h45);
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    tick();
    chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_idle", 32'(idle), 32'h1);
    chkw("mid_rst_done", 512'(done), 512'h0);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    en       = 1'b1;
    tick();

    // round robin with all queues valid, then only queue 2
    jvalid = 4'b1111;
    for (int q = 0; q < 4; q++) jdata[q] = {16{32'(32'hA000_0000 + q)}};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("arb_ready", 32'(jready), 32'(1 << arb_g[k]));
      tick();
      chk("arb_addr", tx_addr, arb_a[k]);
      chk("arb_tag", 32'(tx_tag), 32'(arb_t[k]));
      chkw("arb_data", tx_data, {16{32'(32'hA000_0000 + arb_g[k])}});
    end
    jvalid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("q2_ready", 32'(jready), 32'h4);
      tick();
      chk("q2_addr", tx_addr, 32'(32'h3000 + ((1 + k) % 3)));
      chk("q2_tag", 32'(tx_tag), 32'(8'h81 + k));
    end
    jvalid = 4'b0000;
    tick();
    for (int k = 0; k < 8; k++) respond(arb_r[k]);
    // completion with nothing outstanding must be ignored
    respond(8'h00);
    chkw("arb_done", 512'(done), 512'({32'd1, 32'd4, 32'd1, 32'd2}));

    // backpressure
    jvalid   = 4'b1000;
    jdata[3] = {16{32'hBEEF_0003}};
    #1;
    chk("bp_first_ready", 32'(jready), 32'h8);
    tick();
    jvalid   = 4'b0001;
    jdata[0] = {16{32'hCAFE_0000}};
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(jready), 32'h0);
      tick();
      chk("bp_valid", 32'(tx_valid), 32'h1);
      chk("bp_addr", tx_addr, 32'h4001);
      chk("bp_tag", 32'(tx_tag), 32'hC1);
      chkw("bp_data", tx_data, {16{32'hBEEF_0003}});
    end
    tx_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(jready), 32'h1);
    tick();
    jvalid = 4'b0000;
    chk("bp_next_addr", tx_addr, 32'h1002);
    chk("bp_next_tag", 32'(tx_tag), 32'h02);
    chkw("bp_next_data", tx_data, {16{32'hCAFE_0000}});
    tick();
    chk("bp_hs", 32'(tx_valid), 32'h0);
    respond(8'hC1);
    respond(8'h02);
    chk("bp_done3", done[3], 32'd2);
    chk("bp_done0", done[0], 32'd3);
    chk("bp_nodup", 32'(tx_valid), 32'h0);

    // credit limit
    jvalid = 4'b0001;
    acc    = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (jready[0]) acc++;
      tick();
    end
    chk("credit_fill", 32'(acc), 32'd16);
    acc      = 0;
    rx_valid = 1'b1;
    rx_tag   = 8'h00;
    #1;
    if (jready[0]) acc++;
    tick();
    rx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (jready[0]) acc++;
      tick();
    end
    chk("credit_one", 32'(acc), 32'd1);
    acc = 0;
    for (int k = 0; k < 14; k++) begin
      rx_valid = (k < 8);
      #1;
      if (jready[0]) acc++;
      tick();
    end
    rx_valid = 1'b0;
    chk("credit_simul", 32'(acc), 32'd8);
    #1;
    chk("credit_stall", 32'(jready), 32'h0);

    // drain with 3 outstanding
    jvalid = 4'b0000;
    for (int k = 0; k < 13; k++) respond(8'h00);
    en = 1'b0;
    tick();
    chk("drain_idle0", 32'(idle), 32'h0);
    jvalid = 4'b0001;
    #1;
    chk("drain_ready", 32'(jready), 32'h0);
    respond(8'h00);
    respond(8'h00);
    chk("drain_idle1", 32'(idle), 32'h0);
    respond(8'h00);
    tick();
    chk("drain_done_idle", 32'(idle), 32'h1);
    chk("drain_ready_idle", 32'(jready), 32'h0);
    chk("drain_done0", done[0], 32'd28);
    jvalid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
